// File: rtl/flight_cmd_pkg.sv
// Shared opcodes, FSM states and constants for the flight command sequencer.
// Build option: define CMD_WDOG_EN to enable the command watchdog in flight_cmd_ctrl.
package flight_cmd_pkg;

    localparam int         SPINUP_W_DEF = 26;
    localparam int         WDOG_W       = 26;
    localparam logic [7:0] POS_ACK      = 8'hA5;

    typedef enum logic [7:0] {
        REQ_BATT  = 8'd1,
        SET_PTCH  = 8'd2,
        SET_ROLL  = 8'd3,
        SET_YAW   = 8'd4,
        SET_THRST = 8'd5,
        CALIBRATE = 8'd6,
        EMER_LAND = 8'd7,
        MTRS_OFF  = 8'd8
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        BATT,
        SPINUP,
        CAL,
        ACK,
        WAIT_SENT
    } state_t;

endpackage

// File: rtl/flight_cmd_ctrl_if.sv
// Command/response link between the UART receiver/transmitter and the sequencer.
// master = UART side, slave = flight_cmd_ctrl.
interface flight_cmd_ctrl_if;

    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        output cmd_rdy,
        output cmd,
        output data,
        output resp_sent,
        input  clr_cmd_rdy,
        input  resp,
        input  send_resp
    );

    modport slave (
        input  cmd_rdy,
        input  cmd,
        input  data,
        input  resp_sent,
        output clr_cmd_rdy,
        output resp,
        output send_resp
    );

endinterface

// File: rtl/flight_cmd_ctrl_sat_timer.sv
// Clearable saturating up-counter with an all-ones flag.
// Used for the motor spin-up delay and the command watchdog.
module sat_timer #(
    parameter int W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic full
);

    logic [W-1:0] cnt_q;

    assign full = &cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !full) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/flight_cmd_ctrl.sv
// Flight command sequencer: decodes UART commands into setpoints, calibration and battery reads.
// Build option: define CMD_WDOG_EN for a 26-bit command watchdog that zeroes the setpoints.
module flight_cmd_ctrl
    import flight_cmd_pkg::*;
#(
    parameter int SPINUP_W = SPINUP_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    flight_cmd_ctrl_if.slave    link,
    input  logic [7:0]          batt,
    output logic                strt_cnv,
    input  logic                cnv_cmplt,
    input  logic                cal_done,
    output logic                strt_cal,
    output logic                inertial_cal,
    output logic                motors_off,
    output logic signed [15:0]  d_ptch,
    output logic signed [15:0]  d_roll,
    output logic signed [15:0]  d_yaw,
    output logic [8:0]          thrst
);

    state_t state_q, state_d;
    cmd_t   op;
    logic   consume;
    logic   spin_clr;
    logic   spin_full;
    logic   wdog_fire;
    logic   send_q;
    logic [7:0] resp_q;

    assign op               = cmd_t'(link.cmd);
    assign link.clr_cmd_rdy = consume;
    assign link.send_resp   = send_q;
    assign link.resp        = resp_q;
    assign spin_clr         = consume && (op == CALIBRATE);

    sat_timer #(.W(SPINUP_W)) u_spinup (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (spin_clr),
        .en    (state_q == SPINUP),
        .full  (spin_full)
    );

`ifdef CMD_WDOG_EN
    // Any consumed command restarts it; it then sits at all-ones until the next one.
    sat_timer #(.W(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (consume),
        .en    (1'b1),
        .full  (wdog_fire)
    );
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        consume  = 1'b0;
        strt_cnv = 1'b0;
        strt_cal = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (link.cmd_rdy) begin
                    consume = 1'b1;
                    unique case (op)
                        REQ_BATT: begin
                            strt_cnv = 1'b1;
                            state_d  = BATT;
                        end
                        CALIBRATE: state_d = SPINUP;
                        default:   state_d = ACK;
                    endcase
                end
            end
            BATT: begin
                if (cnv_cmplt) begin
                    state_d = WAIT_SENT;
                end
            end
            SPINUP: begin
                if (spin_full) begin
                    strt_cal = 1'b1;
                    state_d  = CAL;
                end
            end
            CAL: begin
                if (cal_done) begin
                    state_d = ACK;
                end
            end
            ACK: state_d = WAIT_SENT;
            WAIT_SENT: begin
                if (link.resp_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response byte and the level outputs are registered so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q       <= 1'b0;
            resp_q       <= 8'h00;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
        end else begin
            send_q <= 1'b0;
            if (state_q == ACK) begin
                resp_q <= POS_ACK;
                send_q <= 1'b1;
            end
            if (state_q == BATT && cnv_cmplt) begin
                resp_q <= batt;
                send_q <= 1'b1;
            end
            if (strt_cal) begin
                inertial_cal <= 1'b1;
            end
            if (state_q == CAL && cal_done) begin
                inertial_cal <= 1'b0;
            end
            if (consume) begin
                unique case (op)
                    CALIBRATE: motors_off <= 1'b0;
                    MTRS_OFF:  motors_off <= 1'b1;
                    default:   motors_off <= motors_off;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_ptch <= '0;
            d_roll <= '0;
            d_yaw  <= '0;
            thrst  <= '0;
        end else if (consume) begin
            unique case (op)
                SET_PTCH:  d_ptch <= link.data;
                SET_ROLL:  d_roll <= link.data;
                SET_YAW:   d_yaw  <= link.data;
                SET_THRST: thrst  <= link.data[8:0];
                EMER_LAND: begin
                    d_ptch <= '0;
                    d_roll <= '0;
                    d_yaw  <= '0;
                    thrst  <= '0;
                end
                default: begin
                    d_ptch <= d_ptch;
                end
            endcase
        end else if (wdog_fire) begin
            d_ptch <= '0;
            d_roll <= '0;
            d_yaw  <= '0;
            thrst  <= '0;
        end
    end

endmodule
